// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-port general-purpose register file with write-to-read
//               bypass, optional hardwired-zero register and a per-register
//               busy scoreboard for RAW hazard detection on multi-cycle
//               producers.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int HAS_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          we,
    input  logic [NWR*ADDR_W-1:0]   waddr,
    input  logic [NWR*DATA_W-1:0]   wdata,
    input  logic [NRD-1:0]          re,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rbusy,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_ok,
    input  logic                    flush,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int C_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [C_DEPTH];
    logic [C_DEPTH-1:0] r_busy;
    logic [ADDR_W:0]    r_busy_cnt;
    logic [C_DEPTH-1:0] w_busy_next;
    logic [ADDR_W:0]    w_cnt_next;
    logic               w_rsv_zero;

    // Register 0 accepts a reservation but never records it when hardwired.
    assign w_rsv_zero = (HAS_ZERO != 0) && (rsv_addr == '0);
    assign rsv_ok     = rsv_en & ~rst & ~flush & ~r_busy[rsv_addr];
    assign busy_cnt   = r_busy_cnt;

    // Array write; later loop iterations override, so the highest port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < C_DEPTH; j++) begin
                r_regs[j] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && !((HAS_ZERO != 0) && (waddr[k*ADDR_W +: ADDR_W] == '0))) begin
                    r_regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next busy vector: writes clear, a new reservation overrides a same-cycle
    // write (it is a newer producer), and reset/flush wipe everything.
    always_comb begin
        w_busy_next = r_busy;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                w_busy_next[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsv_ok && !w_rsv_zero) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
        if (rst || flush) begin
            w_busy_next = '0;
        end
    end

    // Population count of the next busy vector so the count tracks the bits.
    always_comb begin
        w_cnt_next = '0;
        for (int j = 0; j < C_DEPTH; j++) begin
            w_cnt_next = w_cnt_next + (ADDR_W+1)'(w_busy_next[j]);
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk) begin
        r_busy     <= w_busy_next;
        r_busy_cnt <= w_cnt_next;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_hit;
        logic [DATA_W-1:0] w_byp;

        assign w_addr = raddr[i*ADDR_W +: ADDR_W];
        assign w_zero = (HAS_ZERO != 0) && (w_addr == '0);

        // Bypass search; the highest-numbered matching write port wins.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == w_addr)) begin
                    w_hit = 1'b1;
                    w_byp = wdata[k*DATA_W +: DATA_W];
                end
            end
        end

        // Read data selection in priority order.
        always_comb begin
            if (rst || w_zero || !re[i]) begin
                rdata[i*DATA_W +: DATA_W] = '0;
            end else if (w_hit) begin
                rdata[i*DATA_W +: DATA_W] = w_byp;
            end else begin
                rdata[i*DATA_W +: DATA_W] = r_regs[w_addr];
            end
        end

        assign rbusy[i] = re[i] & ~rst & ~w_zero & r_busy[w_addr] & ~w_hit;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed, table-driven self-checking bench for regfile_sb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_err    = 0;

    regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .HAS_ZERO(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        rsv;
        logic [4:0]  rsa;
        logic        fl;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
        logic [1:0]  x_rb;
        logic        x_ok;
        logic [5:0]  x_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [1:0] w,
        input logic [4:0] a0, input logic [31:0] d0,
        input logic [4:0] a1, input logic [31:0] d1,
        input logic [1:0] e, input logic [4:0] q0, input logic [4:0] q1,
        input logic rv, input logic [4:0] ra, input logic fl,
        input logic [31:0] x0, input logic [31:0] x1,
        input logic [1:0] xb, input logic xo, input logic [5:0] xc);
        vec_t t;
        t.rst = r;  t.we = w;  t.wa0 = a0; t.wd0 = d0; t.wa1 = a1; t.wd1 = d1;
        t.re = e;   t.ra0 = q0; t.ra1 = q1; t.rsv = rv; t.rsa = ra; t.fl = fl;
        t.x_rd0 = x0; t.x_rd1 = x1; t.x_rb = xb; t.x_ok = xo; t.x_cnt = xc;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst      = t.rst;
        we       = t.we;
        waddr    = {t.wa1, t.wa0};
        wdata    = {t.wd1, t.wd0};
        re       = t.re;
        raddr    = {t.ra1, t.ra0};
        rsv_en   = t.rsv;
        rsv_addr = t.rsa;
        flush    = t.fl;
    endtask

    task automatic check_vec(input vec_t t, input int idx);
        chk("rdata0",   idx, rdata[31:0],             t.x_rd0);
        chk("rdata1",   idx, rdata[63:32],            t.x_rd1);
        chk("rbusy",    idx, {30'd0, rbusy},          {30'd0, t.x_rb});
        chk("rsv_ok",   idx, {31'd0, rsv_ok},         {31'd0, t.x_ok});
        chk("busy_cnt", idx, {26'd0, busy_cnt},       {26'd0, t.x_cnt});
    endtask

    // One cycle per record: inputs applied after the falling edge, outputs
    // sampled 1 ns later, state advances on the following rising edge.
    initial begin
        vec_t idle;
        idle = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        //          rst we   wa0 wd0           wa1 wd1    re    ra0 ra1 rsv rsa fl  rd0           rd1           rb    ok cnt
        vecs.push_back(mk(1, 2'b01, 5, 32'hAA,        0, 0,     2'b11, 5, 5,  1, 9,  0, 0,            0,            2'b00, 0, 0)); // 0 reset state
        vecs.push_back(mk(0, 2'b01, 5, 32'hDEADBEEF,  0, 0,     2'b10, 5, 5,  0, 0,  0, 0,            32'hDEADBEEF, 2'b00, 0, 0)); // 1 write r5, bypass on port1, re0=0
        vecs.push_back(mk(0, 2'b01, 0, 32'h1234,      0, 0,     2'b11, 5, 0,  0, 0,  0, 32'hDEADBEEF, 0,            2'b00, 0, 0)); // 2 array r5, r0 write no bypass
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 0, 5,  0, 0,  0, 0,            32'hDEADBEEF, 2'b00, 0, 0)); // 3 r0 stays 0
        vecs.push_back(mk(0, 2'b11, 7, 32'h11,        7, 32'h22,2'b11, 7, 5,  0, 0,  0, 32'h22,       32'hDEADBEEF, 2'b00, 0, 0)); // 4 dual write r7, port1 wins
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 7, 7,  0, 0,  0, 32'h22,       32'h22,       2'b00, 0, 0)); // 5 array r7
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 9, 7,  1, 9,  0, 0,            32'h22,       2'b00, 1, 0)); // 6 reserve r9
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b01, 9, 9,  1, 9,  0, 0,            0,            2'b01, 0, 1)); // 7 busy r9, re-reserve refused
        vecs.push_back(mk(0, 2'b10, 0, 0,             9, 32'h55,2'b11, 9, 9,  0, 0,  0, 32'h55,       32'h55,       2'b00, 0, 1)); // 8 writeback r9
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 9, 9,  0, 0,  0, 32'h55,       32'h55,       2'b00, 0, 0)); // 9 busy cleared
        vecs.push_back(mk(0, 2'b01, 3, 32'h33,        0, 0,     2'b01, 3, 0,  1, 3,  0, 32'h33,       0,            2'b00, 1, 0)); // 10 reserve+write r3
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 3, 0,  1, 0,  0, 32'h33,       0,            2'b01, 1, 1)); // 11 r3 busy, reserve r0 ok
        vecs.push_back(mk(0, 2'b01, 3, 32'h34,        0, 0,     2'b11, 3, 0,  0, 0,  0, 32'h34,       0,            2'b00, 0, 1)); // 12 r0 not counted; clear r3
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b01, 3, 0,  1, 1,  0, 32'h34,       0,            2'b00, 1, 0)); // 13 reserve r1
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 1, 2,  1, 2,  0, 0,            0,            2'b01, 1, 1)); // 14 reserve r2
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 2, 4,  1, 4,  0, 0,            0,            2'b01, 1, 2)); // 15 reserve r4
        vecs.push_back(mk(0, 2'b01, 2, 32'h77,        0, 0,     2'b11, 4, 2,  1, 5,  1, 0,            32'h77,       2'b01, 0, 3)); // 16 flush + write r2
        vecs.push_back(mk(0, 2'b00, 0, 0,             0, 0,     2'b11, 2, 4,  0, 0,  0, 32'h77,       0,            2'b00, 0, 0)); // 17 flushed, r2 landed

        // Initial reset cycle to bring all state to a known value.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

        // Reset mid-operation: r10 holds data and is busy when rst arrives.
        @(negedge clk);
        drive(idle);
        we = 2'b10; waddr = {5'd10, 5'd0}; wdata = {32'hCAFE, 32'd0};
        rsv_en = 1'b1; rsv_addr = 5'd10;
        re = 2'b01; raddr = {5'd0, 5'd10};
        #1;
        chk("pre_rst_rdata", 100, rdata[31:0], 32'hCAFE);
        chk("pre_rst_ok",    100, {31'd0, rsv_ok}, 32'd1);

        @(negedge clk);
        drive(idle);
        re = 2'b11; raddr = {5'd10, 5'd10};
        #1;
        chk("busy_r10",      101, {30'd0, rbusy}, 32'd3);
        chk("busy_cnt_r10",  101, {26'd0, busy_cnt}, 32'd1);
        chk("arr_r10",       101, rdata[63:32], 32'hCAFE);

        @(negedge clk);
        rst = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd11;
        we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'd0, 32'h99};
        #1;
        chk("rst_rdata0",    102, rdata[31:0], 32'd0);
        chk("rst_rdata1",    102, rdata[63:32], 32'd0);
        chk("rst_rbusy",     102, {30'd0, rbusy}, 32'd0);
        chk("rst_rsv_ok",    102, {31'd0, rsv_ok}, 32'd0);

        @(negedge clk);
        drive(idle);
        re = 2'b11; raddr = {5'd12, 5'd10};
        #1;
        chk("post_rst_r10",  103, rdata[31:0], 32'd0);
        chk("post_rst_r12",  103, rdata[63:32], 32'd0);
        chk("post_rst_busy", 103, {30'd0, rbusy}, 32'd0);
        chk("post_rst_cnt",  103, {26'd0, busy_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
